// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        DONE
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    localparam int BYTES_PER_WORD_DEF = 4;
    localparam int BYTE_W             = 8;

endpackage

// File: rtl/mem_port_arbiter_toggle_sync.sv
// Two-flop synchroniser for a two-phase request toggle, plus the pending
// detector that compares the synced phase against the local ack phase.
module toggle_sync (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic ack_phase,
    output logic pending
);

    logic meta;
    logic synced;

    // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= trigger;
            synced <= meta;
        end
    end

    assign pending = synced ^ ack_phase;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising 32-bit fetch and load/store accesses onto a
// byte-wide four-phase memory port. Optional watchdog: define ARB_TIMEOUT_EN.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               fTriggerIn,
    input  logic [ADDR_W-1:0]                  fAddrIn,
    output logic                               fTriggerOut,
    output logic [BYTES_PER_WORD*BYTE_W-1:0]   fDataOut,
    input  logic                               dTriggerIn,
    input  logic [ADDR_W-1:0]                  dAddrIn,
    input  logic                               dWriteIn,
    input  logic [BYTES_PER_WORD*BYTE_W-1:0]   dDataIn,
    output logic                               dTriggerOut,
    output logic [BYTES_PER_WORD*BYTE_W-1:0]   dDataOut,
    output logic [ADDR_W-1:0]                  memAddrOut,
    output logic [BYTE_W-1:0]                  memDataOut,
    output logic                               memWriteOut,
    output logic                               memReqOut,
    input  logic [BYTE_W-1:0]                  memDataIn,
    input  logic                               memReadyIn,
    output logic [1:0]                         errOut
);

    localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam int K_W    = $clog2(BYTES_PER_WORD + 1);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    arb_state_t        state, state_next;
    req_id_t           grant, grant_next, last_grant;
    logic [1:0]        ack_phase;
    logic [1:0]        pending;
    logic [K_W-1:0]    k;
    logic [LANE_W-1:0] lane;
    logic [ADDR_W-1:0] base;
    logic              write;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] result;
    logic              start, capture, advance, finish, timeout;

    toggle_sync u_fetch_sync (
        .clk       (clk),
        .reset     (reset),
        .trigger   (fTriggerIn),
        .ack_phase (ack_phase[REQ_FETCH]),
        .pending   (pending[REQ_FETCH])
    );

    toggle_sync u_data_sync (
        .clk       (clk),
        .reset     (reset),
        .trigger   (dTriggerIn),
        .ack_phase (ack_phase[REQ_DATA]),
        .pending   (pending[REQ_DATA])
    );

    assign lane = k[LANE_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        grant_next = grant;
        start      = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 2'b00) begin
                    start      = 1'b1;
                    state_next = REQ;
                    if (pending == 2'b11)
                        grant_next = (last_grant == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
                    else
                        grant_next = pending[REQ_DATA] ? REQ_DATA : REQ_FETCH;
                end
            end
            REQ: begin
                if (timeout) begin
                    state_next = DONE;
                end else if (memReadyIn) begin
                    capture    = !write;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (timeout) begin
                    state_next = DONE;
                end else if (!memReadyIn) begin
                    advance    = 1'b1;
                    state_next = (k == K_W'(BYTES_PER_WORD - 1)) ? DONE : REQ;
                end
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs decode straight from state so reset drops the request at once.
    assign memReqOut   = (state == REQ);
    assign memWriteOut = (state == REQ) && write;
    assign memDataOut  = memWriteOut ? wdata[BYTE_W*lane +: BYTE_W] : '0;
    assign memAddrOut  = base + ADDR_W'(k);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= REQ_FETCH;
            last_grant  <= REQ_DATA;
            ack_phase   <= 2'b00;
            k           <= '0;
            base        <= '0;
            write       <= 1'b0;
            wdata       <= '0;
            result      <= '0;
            fTriggerOut <= 1'b0;
            dTriggerOut <= 1'b0;
            fDataOut    <= '0;
            dDataOut    <= '0;
        end else begin
            grant <= grant_next;
            if (start) begin
                base   <= (grant_next == REQ_FETCH) ? fAddrIn : dAddrIn;
                write  <= (grant_next == REQ_DATA) && dWriteIn;
                wdata  <= dDataIn;
                result <= '0;  // bytes never received (watchdog) read back as zero
                k      <= '0;
            end
            if (capture) result[BYTE_W*lane +: BYTE_W] <= memDataIn;
            if (advance) k <= k + 1'b1;
            if (finish) begin
                ack_phase[grant] <= ~ack_phase[grant];
                last_grant       <= grant;
                if (grant == REQ_FETCH) begin
                    fTriggerOut <= ~fTriggerOut;
                    fDataOut    <= result;
                end else begin
                    dTriggerOut <= ~dTriggerOut;
                    if (!write) dDataOut <= result;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer;
    logic [1:0]         err;

    assign timeout = ((state == REQ) || (state == RELEASE)) &&
                     (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
            err   <= 2'b00;
        end else begin
            if (state_next != state)
                timer <= '0;
            else if ((state == REQ) || (state == RELEASE))
                timer <= timer + 1'b1;
            if (timeout) err[grant] <= 1'b1;
        end
    end

    assign errOut = err;
`else
    assign timeout = 1'b0;
    assign errOut  = 2'b00;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a byte memory model answers the
// four-phase port, requester tasks push expected words, a monitor checks completions.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fTriggerIn, dTriggerIn, dWriteIn;
    logic [31:0] fAddrIn, dAddrIn, dDataIn;
    logic        fTriggerOut, dTriggerOut;
    logic [31:0] fDataOut, dDataOut, memAddrOut;
    logic [7:0]  memDataOut, memDataIn;
    logic        memWriteOut, memReqOut, memReadyIn;
    logic [1:0]  errOut;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .fTriggerIn(fTriggerIn), .fAddrIn(fAddrIn),
        .fTriggerOut(fTriggerOut), .fDataOut(fDataOut),
        .dTriggerIn(dTriggerIn), .dAddrIn(dAddrIn), .dWriteIn(dWriteIn), .dDataIn(dDataIn),
        .dTriggerOut(dTriggerOut), .dDataOut(dDataOut),
        .memAddrOut(memAddrOut), .memDataOut(memDataOut), .memWriteOut(memWriteOut),
        .memReqOut(memReqOut), .memDataIn(memDataIn), .memReadyIn(memReadyIn),
        .errOut(errOut)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // ---------------- memory model and reference model ----------------
    logic [7:0]  mem    [logic [31:0]];
    logic [7:0]  shadow [logic [31:0]];
    logic [31:0] f_exp[$];
    logic [31:0] d_exp[$];
    logic [31:0] acc_log[$];
    int          order[$];
    int          f_done = 0, d_done = 0;
    int          model_last = 1;
    logic [31:0] model_d_out = '0;
    int          resp_delay = 1;
    bit          stuck = 1'b0;
    bit          proto_en = 1'b1;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5a;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] shadow_word(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ai = a + 32'(i);
            w[8*i +: 8] = shadow.exists(ai) ? shadow[ai] : init_byte(ai);
        end
        return w;
    endfunction

    // Four-phase memory responder; also checks the handshake ordering.
    initial begin
        int  wait_cnt = 0;
        logic prev_req = 1'b0, prev_ready = 1'b0;
        memReadyIn = 1'b0;
        memDataIn  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                memReadyIn = 1'b0;
                wait_cnt   = 0;
                prev_req   = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (proto_en) begin
                    if (prev_req && !memReqOut) check("req_held_until_ready", 32'(prev_ready), 32'd1);
                    if (!prev_req && memReqOut) check("req_after_ready_low", 32'(prev_ready), 32'd0);
                end
                prev_req = memReqOut;
                if (memReqOut && !memReadyIn) begin
                    if (!stuck && wait_cnt >= resp_delay) begin
                        acc_log.push_back(memAddrOut);
                        if (memWriteOut) mem[memAddrOut] = memDataOut;
                        memDataIn  = mem_rd(memAddrOut);
                        memReadyIn = 1'b1;
                        wait_cnt   = 0;
                    end else wait_cnt++;
                end else if (!memReqOut && memReadyIn) begin
                    if (wait_cnt >= resp_delay) begin
                        memReadyIn = 1'b0;
                        memDataIn  = 8'h00;
                        wait_cnt   = 0;
                    end else wait_cnt++;
                end
                prev_ready = memReadyIn;
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done toggle.
    initial begin
        logic pf = 1'b0, pd = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pf = 1'b0;
                pd = 1'b0;
            end else begin
                if (fTriggerOut !== pf) begin
                    pf = fTriggerOut;
                    f_done++;
                    order.push_back(0);
                    model_last = 0;
                    if (f_exp.size() == 0) check("fetch_unexpected_done", 32'd1, 32'd0);
                    else check("fetch_word", fDataOut, f_exp.pop_front());
                end
                if (dTriggerOut !== pd) begin
                    pd = dTriggerOut;
                    d_done++;
                    order.push_back(1);
                    model_last = 1;
                    if (d_exp.size() == 0) check("data_unexpected_done", 32'd1, 32'd0);
                    else check("data_word", dDataOut, d_exp.pop_front());
                end
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic fetch_issue(input logic [31:0] a);
        fAddrIn = a;
        f_exp.push_back(shadow_word(a));
        fTriggerIn = ~fTriggerIn;
    endtask

    task automatic data_issue(input logic [31:0] a, input bit wr, input logic [31:0] wd);
        dAddrIn  = a;
        dWriteIn = wr;
        dDataIn  = wd;
        if (wr) begin
            for (int i = 0; i < 4; i++) shadow[a + 32'(i)] = wd[8*i +: 8];
        end else begin
            model_d_out = shadow_word(a);
        end
        d_exp.push_back(model_d_out);
        dTriggerIn = ~dTriggerIn;
    endtask

    task automatic wait_done(input int f_target, input int d_target, input string name);
        int n = 0;
        while ((f_done < f_target || d_done < d_target) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(f_done >= f_target && d_done >= d_target), 32'd1);
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        fTriggerIn = 1'b0;
        dTriggerIn = 1'b0;
        f_exp.delete();
        d_exp.delete();
        model_d_out = '0;
        model_last  = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic sim_pair(input string name);
        int f0 = f_done, d0 = d_done;
        int first = (model_last == 1) ? 0 : 1;
        order.delete();
        fetch_issue(32'h1000_0020);
        data_issue(32'h2000_0020, 1'b0, 32'h0);
        wait_done(f0 + 1, d0 + 1, {name, "_done"});
        repeat (5) @(negedge clk);
        check({name, "_count"}, 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            check({name, "_first"}, 32'(order[0]), 32'(first));
            check({name, "_second"}, 32'(order[1]), 32'(1 - first));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed and random stimulus ----------------
    initial begin
        int f0, d0;
        bit found;
        reset = 1'b1;
        fTriggerIn = 1'b0; dTriggerIn = 1'b0; dWriteIn = 1'b0;
        fAddrIn = '0; dAddrIn = '0; dDataIn = '0;
        for (int i = 0; i < 4; i++) begin
            mem[32'(i)]    = 8'(i + 1);
            shadow[32'(i)] = 8'(i + 1);
        end
        repeat (3) @(negedge clk);
        check("rst_fTriggerOut", 32'(fTriggerOut), 32'd0);
        check("rst_dTriggerOut", 32'(dTriggerOut), 32'd0);
        check("rst_fDataOut", fDataOut, 32'd0);
        check("rst_dDataOut", dDataOut, 32'd0);
        check("rst_memReqOut", 32'(memReqOut), 32'd0);
        check("rst_memWriteOut", 32'(memWriteOut), 32'd0);
        check("rst_memAddrOut", memAddrOut, 32'd0);
        check("rst_memDataOut", 32'(memDataOut), 32'd0);
        check("rst_errOut", 32'(errOut), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // fetch only, address sequence 0..3
        acc_log.delete();
        f0 = f_done;
        fetch_issue(32'h0);
        wait_done(f0 + 1, 0, "fetch_only_done");
        check("fetch_only_word", fDataOut, 32'h0403_0201);
        check("fetch_only_nbytes", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("fetch_only_addr", acc_log[i], 32'(i));

        // store then load
        d0 = d_done;
        data_issue(32'd8, 1'b1, 32'hDEAD_BEEF);
        wait_done(0, d0 + 1, "store_done");
        check("store_byte8", 32'(mem_rd(32'd8)), 32'hEF);
        check("store_byte9", 32'(mem_rd(32'd9)), 32'hBE);
        check("store_byte10", 32'(mem_rd(32'd10)), 32'hAD);
        check("store_byte11", 32'(mem_rd(32'd11)), 32'hDE);
        check("store_keeps_dDataOut", dDataOut, 32'd0);
        d0 = d_done;
        data_issue(32'd8, 1'b0, 32'h0);
        wait_done(0, d0 + 1, "load_done");
        check("load_word", dDataOut, 32'hDEAD_BEEF);

        // round robin: fresh reset gives fetch the tie; after a lone fetch, data wins
        apply_reset();
        sim_pair("rr_after_reset");
        f0 = f_done;
        fetch_issue(32'h1000_0000);
        wait_done(f0 + 1, 0, "lone_fetch_done");
        sim_pair("rr_after_fetch");

        // slow memory
        resp_delay = 5;
        f0 = f_done; d0 = d_done;
        fetch_issue(32'h1000_0041);
        data_issue(32'h2000_0010, 1'b1, 32'h1234_5678);
        wait_done(f0 + 1, d0 + 1, "slow_pair_done");
        d0 = d_done;
        data_issue(32'h2000_0010, 1'b0, 32'h0);
        wait_done(0, d0 + 1, "slow_load_done");
        resp_delay = 1;

        // reset during byte 2 of a fetch
        f0 = f_done;
        fetch_issue(32'h1000_0100);
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (memReqOut && memAddrOut == 32'h1000_0102) found = 1'b1;
        end
        check("reached_byte2", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("req_drops_on_reset", 32'(memReqOut), 32'd0);
        apply_reset();
        repeat (40) @(negedge clk);
        check("no_done_after_reset", 32'(f_done), 32'(f0));
        check("fTriggerOut_after_reset", 32'(fTriggerOut), 32'd0);
        f0 = f_done;
        fetch_issue(32'h1000_0100);
        wait_done(f0 + 1, 0, "fetch_after_reset_done");

        // randomized concurrent traffic
        for (int round = 0; round < 3; round++) begin
            resp_delay = $urandom_range(0, 3);
            fork
                begin
                    for (int i = 0; i < 10; i++) begin
                        int fb;
                        logic [31:0] a;
                        repeat ($urandom_range(0, 6)) @(negedge clk);
                        if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
                        else a = 32'h1000_0000 + 32'($urandom_range(0, 255));
                        fb = f_done;
                        fetch_issue(a);
                        wait_done(fb + 1, 0, "rand_fetch_done");
                    end
                end
                begin
                    for (int i = 0; i < 10; i++) begin
                        int db;
                        repeat ($urandom_range(0, 6)) @(negedge clk);
                        db = d_done;
                        data_issue(32'h2000_0000 + 32'($urandom_range(0, 63)),
                                   1'($urandom_range(0, 1)), $urandom);
                        wait_done(0, db + 1, "rand_data_done");
                    end
                end
            join
        end
        resp_delay = 1;

`ifdef ARB_TIMEOUT_EN
        proto_en = 1'b0;
        stuck    = 1'b1;
        f0 = f_done;
        fAddrIn = 32'h1000_0200;
        f_exp.push_back(32'h0);
        fTriggerIn = ~fTriggerIn;
        wait_done(f0 + 1, 0, "timeout_fetch_done");
        check("timeout_errOut", 32'(errOut), 32'd1);
        check("timeout_fDataOut", fDataOut, 32'd0);
        stuck = 1'b0;
        repeat (4) @(negedge clk);
        proto_en = 1'b1;
`else
        check("errOut_tied_zero", 32'(errOut), 32'd0);
`endif

        repeat (10) @(negedge clk);
        check("fetch_queue_drained", 32'(f_exp.size()), 32'd0);
        check("data_queue_drained", 32'(d_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
